mc_control_fsm: RTL and testbench

Multicycle main controller for the RV32I core. Sequences the shared datapath over several cycles per instruction: one ALU, one unified memory port and the immediate sign-extend unit. It decodes the latched instruction, drives every datapath select and enable, and generates the immediate-format select for the sign-extend unit. Memory accesses stall on a ready handshake.

---
 rtl/mc_ctrl_pkg.sv | 63 ++++++
 rtl/mc_instr_decoder.sv | 28 ++
 rtl/mc_control_fsm.sv | 188 ++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the RV32I multicycle main controller and its datapath:
// state codes, opcodes, instruction classes and datapath select encodings.
package mc_ctrl_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 7;

  // Controller states
  localparam logic [STATE_W-1:0] S_FETCH    = 4'd0;
  localparam logic [STATE_W-1:0] S_DECODE   = 4'd1;
  localparam logic [STATE_W-1:0] S_MEMADR   = 4'd2;
  localparam logic [STATE_W-1:0] S_MEMREAD  = 4'd3;
  localparam logic [STATE_W-1:0] S_MEMWB    = 4'd4;
  localparam logic [STATE_W-1:0] S_MEMWRITE = 4'd5;
  localparam logic [STATE_W-1:0] S_EXECUTER = 4'd6;
  localparam logic [STATE_W-1:0] S_EXECUTEI = 4'd7;
  localparam logic [STATE_W-1:0] S_ALUWB    = 4'd8;
  localparam logic [STATE_W-1:0] S_BEQ      = 4'd9;
  localparam logic [STATE_W-1:0] S_JAL      = 4'd10;
  localparam logic [STATE_W-1:0] S_ILLEGAL  = 4'd11;

  // Opcodes
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;

  // Datapath select encodings
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALURES  = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'd0;
  localparam logic [1:0] IMM_S = 2'd1;
  localparam logic [1:0] IMM_B = 2'd2;
  localparam logic [1:0] IMM_J = 2'd3;

  // Instruction class produced by the decoder
  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_LOAD   = 3'd1,
    CLS_STORE  = 3'd2,
    CLS_RTYPE  = 3'd3,
    CLS_ITYPE  = 3'd4,
    CLS_BRANCH = 3'd5,
    CLS_JAL    = 3'd6
  } instr_cls_e;

endpackage

// File: rtl/mc_instr_decoder.sv
// Combinational opcode decoder: instruction class for the FSM and the
// immediate format select for the sign-extend unit.
//   opcode       in  7  instr[6:0]
//   cls          out    instruction class
//   imm_ext_cont out 2  immediate format (I/S/B/J)
module mc_instr_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output instr_cls_e cls,
  output logic [1:0] imm_ext_cont
);

  always_comb begin
    cls          = CLS_NONE;
    imm_ext_cont = IMM_I;
    case (opcode)
      OP_LOAD:   begin cls = CLS_LOAD;   imm_ext_cont = IMM_I; end
      OP_STORE:  begin cls = CLS_STORE;  imm_ext_cont = IMM_S; end
      OP_RTYPE:  begin cls = CLS_RTYPE;  imm_ext_cont = IMM_I; end
      OP_ITYPE:  begin cls = CLS_ITYPE;  imm_ext_cont = IMM_I; end
      OP_BRANCH: begin cls = CLS_BRANCH; imm_ext_cont = IMM_B; end
      OP_JAL:    begin cls = CLS_JAL;    imm_ext_cont = IMM_J; end
      default:   begin cls = CLS_NONE;   imm_ext_cont = IMM_I; end
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle main controller for the RV32I core. Sequences the shared ALU,
// unified memory port and sign-extend unit; memory states stall on mem_ready.
// Optional feature macro: MC_CTRL_ILLEGAL_TRAP_EN (trap unknown opcodes in
// an ILLEGAL state and expose illegal_instr).
//   clk, rst        clock, synchronous active-high reset
//   opcode          instr[6:0] from IR
//   funct3_0        instr[12] (0 = beq, 1 = bne)
//   zero            ALU zero flag
//   mem_ready       memory completes access this cycle
//   pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
//   alu_src_b, alu_op, reg_write  datapath controls (combinational)
//   imm_ext_cont    immediate format select
//   state_o         current state for debug/trace
//   illegal_instr   high in ILLEGAL (only with MC_CTRL_ILLEGAL_TRAP_EN)
module mc_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       funct3_0,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic [1:0] imm_ext_cont,
  output logic [3:0] state_o
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic       illegal_instr
`endif
);

  logic [STATE_W-1:0] state_q, state_d;
  instr_cls_e         cls;
  logic [1:0]         imm_dec;

  mc_instr_decoder u_dec (
    .opcode       (opcode),
    .cls          (cls),
    .imm_ext_cont (imm_dec)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next state and datapath controls
  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    reg_write  = 1'b0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    illegal_instr = 1'b0;
`endif

    case (state_q)
      S_FETCH: begin
        adr_src    = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALURES;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // OldPC + imm: branch target parked in ALUOut
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
        case (cls)
          CLS_LOAD, CLS_STORE: state_d = S_MEMADR;
          CLS_RTYPE:           state_d = S_EXECUTER;
          CLS_ITYPE:           state_d = S_EXECUTEI;
          CLS_BRANCH:          state_d = S_BEQ;
          CLS_JAL:             state_d = S_JAL;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          default:             state_d = S_ILLEGAL;
`else
          default:             state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
        // IR is stable for the whole instruction, so the class is still valid
        state_d   = (cls == CLS_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
        mem_write  = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        // funct3[0] inverts the condition for bne
        pc_write   = zero ^ funct3_0;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        state_d    = S_ALUWB;
      end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      S_ILLEGAL: begin
        illegal_instr = 1'b1;
        state_d       = S_ILLEGAL;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    // Reset masks every output so nothing reaches the datapath mid-abort
    if (rst) begin
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      reg_write  = 1'b0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      illegal_instr = 1'b0;
`endif
    end
  end

  assign imm_ext_cont = rst ? 2'b00 : imm_dec;
  assign state_o      = rst ? 4'd0  : state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: per-cycle vector table plus
// hand-written reset-abort and unknown-opcode sequences.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       funct3_0, zero, mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_ext_cont;
  logic [3:0] state_o;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic       illegal_instr;
`endif

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .funct3_0     (funct3_0),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .adr_src      (adr_src),
    .mem_write    (mem_write),
    .ir_write     (ir_write),
    .result_src   (result_src),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .reg_write    (reg_write),
    .imm_ext_cont (imm_ext_cont),
    .state_o      (state_o)
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    ,
    .illegal_instr(illegal_instr)
`endif
  );

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  // One cycle: inputs, expected state, enables {pc,ir,mw,rw}, imm format
  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic       f3;
    logic       z;
    logic       mr;
    logic [3:0] st;
    logic [3:0] en;
    logic [1:0] imm;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input logic r, input logic [6:0] op, input logic f3,
                              input logic z, input logic mr, input logic [3:0] st,
                              input logic [3:0] en, input logic [1:0] imm);
    vec_t v;
    v.rst = r; v.op = op; v.f3 = f3; v.z = z; v.mr = mr;
    v.st = st; v.en = en; v.imm = imm;
    return v;
  endfunction

  // Expected {adr_src, result_src, alu_src_a, alu_src_b, alu_op} per state
  function automatic logic [8:0] sel_model(input logic [3:0] st);
    case (st)
      4'd0:    return {1'b0, 2'b10, 2'b00, 2'b10, 2'b00};
      4'd1:    return {1'b0, 2'b00, 2'b01, 2'b01, 2'b00};
      4'd2:    return {1'b0, 2'b00, 2'b10, 2'b01, 2'b00};
      4'd3:    return {1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
      4'd4:    return {1'b0, 2'b01, 2'b00, 2'b00, 2'b00};
      4'd5:    return {1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
      4'd6:    return {1'b0, 2'b00, 2'b10, 2'b00, 2'b10};
      4'd7:    return {1'b0, 2'b00, 2'b10, 2'b01, 2'b10};
      4'd8:    return {1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
      4'd9:    return {1'b0, 2'b00, 2'b10, 2'b00, 2'b01};
      4'd10:   return {1'b0, 2'b00, 2'b01, 2'b10, 2'b00};
      default: return 9'd0;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp, input int idx);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle, queue the expectation, compare on the falling edge
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    rst       = v.rst;
    opcode    = v.op;
    funct3_0  = v.f3;
    zero      = v.z;
    mem_ready = v.mr;
    if (v.rst) begin
      opcode    = 7'($urandom);
      funct3_0  = 1'($urandom);
      zero      = 1'($urandom);
      mem_ready = 1'($urandom);
    end
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    check("state", int'(state_o), int'(e.rst ? 4'd0 : e.st), idx);
    check("enables", int'({pc_write, ir_write, mem_write, reg_write}),
          int'(e.rst ? 4'd0 : e.en), idx);
    check("selects", int'({adr_src, result_src, alu_src_a, alu_src_b, alu_op}),
          int'(e.rst ? 9'd0 : sel_model(e.st)), idx);
    check("imm_ext_cont", int'(imm_ext_cont), int'(e.rst ? 2'd0 : e.imm), idx);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    check("illegal_instr", int'(illegal_instr), int'(!e.rst && e.st == 4'd11), idx);
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held two cycles with random inputs
    vecs.push_back(mk(1, LW, 0, 0, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(1, LW, 0, 0, 0, 0, 4'b0000, 0));
    // lw with two MEMREAD stalls: 0,1,2,3,3,3,4
    vecs.push_back(mk(0, LW, 0, 0, 1, 0, 4'b1100, 0));
    vecs.push_back(mk(0, LW, 0, 0, 0, 1, 4'b0000, 0));
    vecs.push_back(mk(0, LW, 0, 0, 1, 2, 4'b0000, 0));
    vecs.push_back(mk(0, LW, 0, 0, 0, 3, 4'b0000, 0));
    vecs.push_back(mk(0, LW, 0, 0, 0, 3, 4'b0000, 0));
    vecs.push_back(mk(0, LW, 0, 0, 1, 3, 4'b0000, 0));
    vecs.push_back(mk(0, LW, 0, 0, 0, 4, 4'b0001, 0));
    // sw: 0,1,2,5
    vecs.push_back(mk(0, SW, 0, 0, 1, 0, 4'b1100, 1));
    vecs.push_back(mk(0, SW, 0, 0, 1, 1, 4'b0000, 1));
    vecs.push_back(mk(0, SW, 0, 0, 1, 2, 4'b0000, 1));
    vecs.push_back(mk(0, SW, 0, 0, 1, 5, 4'b0010, 1));
    // beq taken, with a FETCH stall first
    vecs.push_back(mk(0, BR, 0, 1, 0, 0, 4'b0000, 2));
    vecs.push_back(mk(0, BR, 0, 1, 1, 0, 4'b1100, 2));
    vecs.push_back(mk(0, BR, 0, 1, 0, 1, 4'b0000, 2));
    vecs.push_back(mk(0, BR, 0, 1, 0, 9, 4'b1000, 2));
    // bne with zero=1: not taken
    vecs.push_back(mk(0, BR, 1, 1, 1, 0, 4'b1100, 2));
    vecs.push_back(mk(0, BR, 1, 1, 1, 1, 4'b0000, 2));
    vecs.push_back(mk(0, BR, 1, 1, 1, 9, 4'b0000, 2));
    // beq with zero=0: not taken
    vecs.push_back(mk(0, BR, 0, 0, 1, 0, 4'b1100, 2));
    vecs.push_back(mk(0, BR, 0, 0, 1, 1, 4'b0000, 2));
    vecs.push_back(mk(0, BR, 0, 0, 1, 9, 4'b0000, 2));
    // bne with zero=0: taken
    vecs.push_back(mk(0, BR, 1, 0, 1, 0, 4'b1100, 2));
    vecs.push_back(mk(0, BR, 1, 0, 1, 1, 4'b0000, 2));
    vecs.push_back(mk(0, BR, 1, 0, 0, 9, 4'b1000, 2));
    // jal: 0,1,10,8
    vecs.push_back(mk(0, JL, 0, 0, 1, 0, 4'b1100, 3));
    vecs.push_back(mk(0, JL, 0, 0, 1, 1, 4'b0000, 3));
    vecs.push_back(mk(0, JL, 0, 0, 0, 10, 4'b1000, 3));
    vecs.push_back(mk(0, JL, 0, 0, 0, 8, 4'b0001, 3));
    // R-type: 0,1,6,8
    vecs.push_back(mk(0, RT, 0, 0, 1, 0, 4'b1100, 0));
    vecs.push_back(mk(0, RT, 0, 0, 0, 1, 4'b0000, 0));
    vecs.push_back(mk(0, RT, 0, 0, 0, 6, 4'b0000, 0));
    vecs.push_back(mk(0, RT, 0, 0, 1, 8, 4'b0001, 0));
    // I-ALU: 0,1,7,8
    vecs.push_back(mk(0, IT, 0, 0, 1, 0, 4'b1100, 0));
    vecs.push_back(mk(0, IT, 0, 0, 1, 1, 4'b0000, 0));
    vecs.push_back(mk(0, IT, 0, 0, 1, 7, 4'b0000, 0));
    vecs.push_back(mk(0, IT, 0, 0, 1, 8, 4'b0001, 0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset during a MEMWRITE stall aborts the store
    apply(mk(0, SW, 0, 0, 1, 0, 4'b1100, 1), 100);
    apply(mk(0, SW, 0, 0, 1, 1, 4'b0000, 1), 101);
    apply(mk(0, SW, 0, 0, 1, 2, 4'b0000, 1), 102);
    apply(mk(0, SW, 0, 0, 0, 5, 4'b0010, 1), 103);
    apply(mk(0, SW, 0, 0, 0, 5, 4'b0010, 1), 104);
    apply(mk(1, SW, 0, 0, 0, 0, 4'b0000, 0), 105);
    apply(mk(0, BAD, 0, 0, 0, 0, 4'b0000, 0), 106);

    // Unknown opcode
    apply(mk(0, BAD, 0, 0, 1, 0, 4'b1100, 0), 110);
    apply(mk(0, BAD, 0, 0, 1, 1, 4'b0000, 0), 111);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++)
      apply(mk(0, BAD, 1'($urandom), 1'($urandom), 1'($urandom), 11, 4'b0000, 0), 120 + i);
    apply(mk(1, BAD, 0, 0, 1, 0, 4'b0000, 0), 130);
    apply(mk(0, LW, 0, 0, 1, 0, 4'b1100, 0), 131);
`else
    apply(mk(0, BAD, 0, 0, 1, 0, 4'b1100, 0), 112);
    apply(mk(0, BAD, 0, 0, 1, 1, 4'b0000, 0), 113);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
